// File: rtl/issue_scoreboard.sv
// N-wide in-order issue hazard unit with a per-register load-latency countdown scoreboard.
// Optional hazard statistics counters are built when HAZARD_STATS_EN is defined.
module issue_scoreboard #(
  parameter int unsigned ISSUE_W  = 2,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned REG_W    = 5,
  parameter int unsigned LOAD_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [ISSUE_W-1:0]       slot_valid_i,
  input  logic [ISSUE_W-1:0]       slot_rs_used_i,
  input  logic [ISSUE_W-1:0]       slot_rt_used_i,
  input  logic [ISSUE_W-1:0]       slot_dst_used_i,
  input  logic [ISSUE_W-1:0]       slot_is_load_i,
  input  logic [ISSUE_W*REG_W-1:0] slot_rs_i,
  input  logic [ISSUE_W*REG_W-1:0] slot_rt_i,
  input  logic [ISSUE_W*REG_W-1:0] slot_dst_i,
  input  logic                     flush_i,
  output logic [ISSUE_W-1:0]       issue_mask_o,
  output logic                     stall_o,
  output logic [31:0]              stall_cycles_o,
  output logic [15:0]              load_use_cnt_o
);

  localparam int unsigned CNT_W = $clog2(LOAD_LAT + 1);

  logic [CNT_W-1:0]   busy_q [NUM_REGS];
  logic [CNT_W-1:0]   busy_d [NUM_REGS];
  logic [REG_W-1:0]   rs     [ISSUE_W];
  logic [REG_W-1:0]   rt     [ISSUE_W];
  logic [REG_W-1:0]   dst    [ISSUE_W];
  logic [ISSUE_W-1:0] rs_chk;
  logic [ISSUE_W-1:0] rt_chk;
  logic [ISSUE_W-1:0] dst_chk;
  logic [ISSUE_W-1:0] lu_hit;
  logic [ISSUE_W-1:0] blocked;
  logic [ISSUE_W-1:0] issue_mask;
  logic               stall;

  // Unpack slot fields; register 0 never takes part in any hazard.
  always_comb begin : unpack
    for (int k = 0; k < ISSUE_W; k++) begin
      rs[k]      = slot_rs_i[k*REG_W +: REG_W];
      rt[k]      = slot_rt_i[k*REG_W +: REG_W];
      dst[k]     = slot_dst_i[k*REG_W +: REG_W];
      rs_chk[k]  = slot_rs_used_i[k]  && (rs[k]  != '0);
      rt_chk[k]  = slot_rt_used_i[k]  && (rt[k]  != '0);
      dst_chk[k] = slot_dst_used_i[k] && (dst[k] != '0);
    end
  end

  always_comb begin : hazard
    lu_hit  = '0;
    blocked = '0;
    for (int k = 0; k < ISSUE_W; k++) begin
      lu_hit[k]  = slot_valid_i[k] &&
                   ((rs_chk[k] && (busy_q[rs[k]] != '0)) ||
                    (rt_chk[k] && (busy_q[rt[k]] != '0)));
      blocked[k] = lu_hit[k] || (dst_chk[k] && (busy_q[dst[k]] != '0));
      // Older writers in the same bundle: RAW on sources, WAW on destination.
      for (int j = 0; j < k; j++) begin
        if (slot_valid_i[j] && dst_chk[j]) begin
          if ((rs_chk[k]  && (rs[k]  == dst[j])) ||
              (rt_chk[k]  && (rt[k]  == dst[j])) ||
              (dst_chk[k] && (dst[k] == dst[j]))) begin
            blocked[k] = 1'b1;
          end
        end
      end
    end
  end

  // In-order issue: the first blocked slot holds itself and every younger slot.
  always_comb begin : issue
    logic ok;
    ok         = !flush_i;
    issue_mask = '0;
    for (int k = 0; k < ISSUE_W; k++) begin
      ok            = ok && slot_valid_i[k] && !blocked[k];
      issue_mask[k] = ok;
    end
  end

  assign stall        = (|(slot_valid_i & ~issue_mask)) && !flush_i;
  assign issue_mask_o = issue_mask;
  assign stall_o      = stall;

  always_comb begin : busy_next
    for (int r = 0; r < NUM_REGS; r++) begin
      busy_d[r] = (busy_q[r] != '0) ? busy_q[r] - CNT_W'(1) : '0;
    end
    for (int k = 0; k < ISSUE_W; k++) begin
      if (issue_mask[k] && slot_is_load_i[k] && dst_chk[k]) begin
        busy_d[dst[k]] = CNT_W'(LOAD_LAT);
      end
    end
    busy_d[0] = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        busy_q[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        busy_q[r] <= busy_d[r];
      end
    end
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [15:0] load_use_q, load_use_d;

  // Saturating event counters.
  always_comb begin : stats_next
    stall_cycles_d = stall_cycles_q;
    load_use_d     = load_use_q;
    if (stall && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + 32'(1);
    end
    if ((|lu_hit) && (load_use_q != '1)) begin
      load_use_d = load_use_q + 16'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q <= '0;
      load_use_q     <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      load_use_q     <= load_use_d;
    end
  end

  assign stall_cycles_o = stall_cycles_q;
  assign load_use_cnt_o = load_use_q;
`else
  assign stall_cycles_o = '0;
  assign load_use_cnt_o = '0;
`endif

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard: three instances (2-wide L=1, 4-wide L=3, 2-wide L=2)
// share field stimulus; each gets its own valid vector so only the instance under test acts.
module tb_issue_scoreboard;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic [1:0]  va;
  logic [3:0]  vb;
  logic [1:0]  vc;
  logic [3:0]  rs_u, rt_u, dst_u, ld;
  logic [19:0] rs, rt, dst;

  logic [1:0]  mask_a, mask_c;
  logic [3:0]  mask_b;
  logic        stall_a, stall_b, stall_c;
  logic [31:0] sc_a, sc_b, sc_c;
  logic [15:0] lu_a, lu_b, lu_c;

  int n_chk;
  int n_err;

  issue_scoreboard #(.ISSUE_W(2), .NUM_REGS(32), .REG_W(5), .LOAD_LAT(1)) u_a (
    .clk(clk), .rst_n(rst_n), .slot_valid_i(va),
    .slot_rs_used_i(rs_u[1:0]), .slot_rt_used_i(rt_u[1:0]),
    .slot_dst_used_i(dst_u[1:0]), .slot_is_load_i(ld[1:0]),
    .slot_rs_i(rs[9:0]), .slot_rt_i(rt[9:0]), .slot_dst_i(dst[9:0]),
    .flush_i(flush), .issue_mask_o(mask_a), .stall_o(stall_a),
    .stall_cycles_o(sc_a), .load_use_cnt_o(lu_a)
  );

  issue_scoreboard #(.ISSUE_W(4), .NUM_REGS(32), .REG_W(5), .LOAD_LAT(3)) u_b (
    .clk(clk), .rst_n(rst_n), .slot_valid_i(vb),
    .slot_rs_used_i(rs_u), .slot_rt_used_i(rt_u),
    .slot_dst_used_i(dst_u), .slot_is_load_i(ld),
    .slot_rs_i(rs), .slot_rt_i(rt), .slot_dst_i(dst),
    .flush_i(flush), .issue_mask_o(mask_b), .stall_o(stall_b),
    .stall_cycles_o(sc_b), .load_use_cnt_o(lu_b)
  );

  issue_scoreboard #(.ISSUE_W(2), .NUM_REGS(32), .REG_W(5), .LOAD_LAT(2)) u_c (
    .clk(clk), .rst_n(rst_n), .slot_valid_i(vc),
    .slot_rs_used_i(rs_u[1:0]), .slot_rt_used_i(rt_u[1:0]),
    .slot_dst_used_i(dst_u[1:0]), .slot_is_load_i(ld[1:0]),
    .slot_rs_i(rs[9:0]), .slot_rt_i(rt[9:0]), .slot_dst_i(dst[9:0]),
    .flush_i(flush), .issue_mask_o(mask_c), .stall_o(stall_c),
    .stall_cycles_o(sc_c), .load_use_cnt_o(lu_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    va = '0; vb = '0; vc = '0; flush = 1'b0;
    rs_u = '0; rt_u = '0; dst_u = '0; ld = '0;
    rs = '0; rt = '0; dst = '0;
  endtask

  task automatic set_slot(input int k, input logic ru, input logic [4:0] rsv,
                          input logic tu, input logic [4:0] rtv,
                          input logic du, input logic [4:0] dv, input logic l);
    rs_u[k] = ru; rs[k*5 +: 5] = rsv;
    rt_u[k] = tu; rt[k*5 +: 5] = rtv;
    dst_u[k] = du; dst[k*5 +: 5] = dv;
    ld[k] = l;
  endtask

  // Inputs change on the falling edge; outputs are checked 1 time unit later.
  task automatic cyc();
    @(negedge clk);
    clr();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    clr();
    #1;
    chk("rst_mask_a", 32'(mask_a), 32'h0);
    chk("rst_stall_a", 32'(stall_a), 32'h0);
    chk("rst_sc_a", sc_a, 32'h0);
    chk("rst_lu_b", 32'(lu_b), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Load-use, L=1: LW r3 then ADD r4=r3+r1
    cyc(); set_slot(0, 1, 5'd1, 0, 5'd0, 1, 5'd3, 1); va = 2'b01; #1;
    chk("t1_lw_mask", 32'(mask_a), 32'h1);
    cyc(); set_slot(0, 1, 5'd3, 1, 5'd1, 1, 5'd4, 0); va = 2'b01; #1;
    chk("t1_use_mask", 32'(mask_a), 32'h0);
    chk("t1_use_stall", 32'(stall_a), 32'h1);
    cyc(); set_slot(0, 1, 5'd3, 1, 5'd1, 1, 5'd4, 0); va = 2'b01; #1;
    chk("t1_go_mask", 32'(mask_a), 32'h1);
    chk("t1_go_stall", 32'(stall_a), 32'h0);

    // Load-use, 4-wide L=3: LW r7, reader blocked three cycles
    cyc(); set_slot(0, 1, 5'd2, 0, 5'd0, 1, 5'd7, 1); vb = 4'b0001; #1;
    chk("t3_lw_mask", 32'(mask_b), 32'h1);
    for (int i = 1; i <= 3; i++) begin
      cyc(); set_slot(0, 1, 5'd7, 1, 5'd1, 1, 5'd8, 0); vb = 4'b0001; #1;
      chk($sformatf("t3_blk%0d_mask", i), 32'(mask_b), 32'h0);
      chk($sformatf("t3_blk%0d_stall", i), 32'(stall_b), 32'h1);
    end
    cyc(); set_slot(0, 1, 5'd7, 1, 5'd1, 1, 5'd8, 0); vb = 4'b0001; #1;
    chk("t3_go_mask", 32'(mask_b), 32'h1);

`ifdef HAZARD_STATS_EN
    chk("stat_sc_a", sc_a, 32'd1);
    chk("stat_lu_a", 32'(lu_a), 32'd1);
    chk("stat_sc_b", sc_b, 32'd3);
    chk("stat_lu_b", 32'(lu_b), 32'd3);
    chk("stat_sc_sum", sc_a + sc_b, 32'd4);
    chk("stat_lu_sum", 32'(lu_a) + 32'(lu_b), 32'd4);
`else
    chk("stat_sc_a", sc_a, 32'd0);
    chk("stat_lu_b", 32'(lu_b), 32'd0);
`endif

    // Intra-bundle RAW: ADDI r5; SUB r6=r5-r2
    cyc();
    set_slot(0, 1, 5'd1, 0, 5'd0, 1, 5'd5, 0);
    set_slot(1, 1, 5'd5, 1, 5'd2, 1, 5'd6, 0);
    va = 2'b11; #1;
    chk("t2_raw_mask", 32'(mask_a), 32'h1);
    chk("t2_raw_stall", 32'(stall_a), 32'h1);
    cyc(); set_slot(0, 1, 5'd5, 1, 5'd2, 1, 5'd6, 0); va = 2'b01; #1;
    chk("t2_resub_mask", 32'(mask_a), 32'h1);
    chk("t2_resub_stall", 32'(stall_a), 32'h0);

    // Intra-bundle WAW on r10
    cyc();
    set_slot(0, 1, 5'd1, 0, 5'd0, 1, 5'd10, 0);
    set_slot(1, 1, 5'd2, 0, 5'd0, 1, 5'd10, 0);
    va = 2'b11; #1;
    chk("waw_bundle_mask", 32'(mask_a), 32'h1);

    // 4-wide: slot1 RAW on slot0 holds independent younger slots too
    cyc();
    set_slot(0, 1, 5'd1, 0, 5'd0, 1, 5'd14, 0);
    set_slot(1, 0, 5'd0, 1, 5'd14, 1, 5'd15, 0);
    set_slot(2, 1, 5'd2, 0, 5'd0, 1, 5'd16, 0);
    set_slot(3, 1, 5'd3, 0, 5'd0, 1, 5'd17, 0);
    vb = 4'b1111; #1;
    chk("inorder_mask_b", 32'(mask_b), 32'h1);
    chk("inorder_stall_b", 32'(stall_b), 32'h1);

    // 4-wide all independent
    cyc();
    set_slot(0, 1, 5'd1, 0, 5'd0, 1, 5'd14, 0);
    set_slot(1, 1, 5'd2, 0, 5'd0, 1, 5'd15, 0);
    set_slot(2, 1, 5'd3, 0, 5'd0, 1, 5'd16, 0);
    set_slot(3, 1, 5'd4, 0, 5'd0, 1, 5'd17, 1);
    vb = 4'b1111; #1;
    chk("indep_mask_b", 32'(mask_b), 32'hF);

    // WAW against busy: LW r11 then ADDI r11
    idle(4);
    cyc(); set_slot(0, 1, 5'd1, 0, 5'd0, 1, 5'd11, 1); vb = 4'b0001; #1;
    chk("waw_lw_mask", 32'(mask_b), 32'h1);
    cyc(); set_slot(0, 1, 5'd1, 0, 5'd0, 1, 5'd11, 0); vb = 4'b0001; #1;
    chk("waw_busy_mask", 32'(mask_b), 32'h0);
    // Unused source field naming a busy register is ignored
    cyc(); set_slot(0, 0, 5'd11, 1, 5'd1, 1, 5'd12, 0); vb = 4'b0001; #1;
    chk("unused_src_mask", 32'(mask_b), 32'h1);

    // Register 0: LW r0 creates no hazard; r0 ignored within a bundle
    cyc(); set_slot(0, 1, 5'd1, 0, 5'd0, 1, 5'd0, 1); va = 2'b01; #1;
    chk("t4_lw0_mask", 32'(mask_a), 32'h1);
    cyc(); set_slot(0, 1, 5'd0, 1, 5'd0, 1, 5'd1, 0); va = 2'b01; #1;
    chk("t4_use0_mask", 32'(mask_a), 32'h1);
    chk("t4_use0_stall", 32'(stall_a), 32'h0);
    cyc();
    set_slot(0, 1, 5'd1, 0, 5'd0, 1, 5'd0, 0);
    set_slot(1, 1, 5'd0, 1, 5'd0, 1, 5'd0, 0);
    va = 2'b11; #1;
    chk("t4_bundle0_mask", 32'(mask_a), 32'h3);

    // Flush, L=2: LW r9; flush cycle; reader on rt blocked t+2, issues t+3
    cyc(); set_slot(0, 1, 5'd1, 0, 5'd0, 1, 5'd9, 1); vc = 2'b01; #1;
    chk("t5_lw_mask", 32'(mask_c), 32'h1);
    cyc(); set_slot(0, 1, 5'd1, 1, 5'd9, 1, 5'd12, 0); vc = 2'b01; flush = 1'b1; #1;
    chk("t5_flush_mask", 32'(mask_c), 32'h0);
    chk("t5_flush_stall", 32'(stall_c), 32'h0);
    cyc(); set_slot(0, 1, 5'd1, 1, 5'd9, 1, 5'd12, 0); vc = 2'b01; #1;
    chk("t5_blk_mask", 32'(mask_c), 32'h0);
    chk("t5_blk_stall", 32'(stall_c), 32'h1);
    cyc(); set_slot(0, 1, 5'd1, 1, 5'd9, 1, 5'd12, 0); vc = 2'b01; #1;
    chk("t5_go_mask", 32'(mask_c), 32'h1);

    // Reset mid-run discards in-flight load state and counters
    cyc(); set_slot(0, 1, 5'd1, 0, 5'd0, 1, 5'd13, 1); vc = 2'b01; #1;
    chk("rst_lw_mask", 32'(mask_c), 32'h1);
    cyc(); rst_n = 1'b0; #1;
    chk("midrst_sc_a", sc_a, 32'h0);
    chk("midrst_lu_a", 32'(lu_a), 32'h0);
    chk("midrst_sc_c", sc_c, 32'h0);
    chk("midrst_lu_c", 32'(lu_c), 32'h0);
    #2 rst_n = 1'b1;
    set_slot(0, 1, 5'd13, 0, 5'd0, 1, 5'd14, 0); vc = 2'b01; #1;
    chk("postrst_mask", 32'(mask_c), 32'h1);
    chk("postrst_stall", 32'(stall_c), 32'h0);

    idle(1);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
